// File: rtl/strait_pkg.sv
// Shared constants for the eNVM pattern loader: frame header codes, target
// select and error encodings, and record byte counts.
package strait_pkg;

    localparam logic [7:0] HdrSa    = 8'hA5;
    localparam logic [7:0] HdrTd    = 8'h5A;
    localparam logic [7:0] HdrMbist = 8'h3C;

    typedef enum logic [1:0] {
        SelNone  = 2'd0,
        SelSa    = 2'd1,
        SelTd    = 2'd2,
        SelMbist = 2'd3
    } nvm_sel_e;

    typedef enum logic [1:0] {
        ErrOk     = 2'd0,
        ErrHeader = 2'd1,
        ErrCount  = 2'd2,
        ErrCsum   = 2'd3
    } err_e;

    localparam int unsigned DefWeightWidth = 8;
    localparam int unsigned DefActWidth    = 8;
    localparam int unsigned DefPsumWidth   = 19;

    function automatic int unsigned bytes_per_field(input int unsigned width);
        return (width + 7) / 8;
    endfunction

    localparam int unsigned SaRecBytes = bytes_per_field(DefWeightWidth)
        + bytes_per_field(DefActWidth) + 2 * bytes_per_field(DefPsumWidth);
    localparam int unsigned TdRecBytes = 2 * bytes_per_field(DefWeightWidth)
        + 2 * bytes_per_field(DefActWidth) + 4 * bytes_per_field(DefPsumWidth);
    localparam int unsigned MbistRecBytes = bytes_per_field(DefPsumWidth);

endpackage

// File: rtl/envm_pattern_loader_field_assembler.sv
// Places little-endian stream bytes at their packed bit offsets within one
// record and flags the final byte of the record.
module envm_pattern_loader_field_assembler
    import strait_pkg::*;
#(
    parameter int unsigned WeightWidth = 8,
    parameter int unsigned ActWidth    = 8,
    parameter int unsigned PsumWidth   = 19,
    parameter int unsigned RecordWidth = 2 * WeightWidth + 2 * ActWidth + 4 * PsumWidth
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   valid_i,
    input  nvm_sel_e               sel_i,
    input  logic [7:0]             byte_i,
    output logic [RecordWidth-1:0] data_o,
    output logic                   last_o
);

    localparam int unsigned OffW = $clog2(RecordWidth) + 1;

    logic [2:0]             fld_q;
    logic [2:0]             byt_q;
    logic [OffW-1:0]        base_q;
    logic [RecordWidth-1:0] data_q;

    int unsigned            fld_w;
    int unsigned            rem;
    int unsigned            nbits;
    int unsigned            n_fields;
    logic                   field_last;
    logic [7:0]             mask;
    logic [RecordWidth-1:0] placed;

    function automatic int unsigned field_width(input nvm_sel_e sel, input logic [2:0] fld);
        case (sel)
            SelSa:   return (fld == 3'd0) ? WeightWidth : (fld == 3'd1) ? ActWidth : PsumWidth;
            SelTd:   return (fld < 3'd2) ? WeightWidth : (fld < 3'd4) ? ActWidth : PsumWidth;
            SelMbist: return PsumWidth;
            default: return 8;
        endcase
    endfunction

    always_comb begin
        fld_w = field_width(sel_i, fld_q);
        case (sel_i)
            SelSa:   n_fields = 4;
            SelTd:   n_fields = 8;
            default: n_fields = 1;
        endcase
        field_last = (32'(byt_q) + 1 == bytes_per_field(fld_w));
        last_o     = field_last && (32'(fld_q) + 1 == n_fields);
        // Bits beyond the field width in its top byte are dropped here.
        rem    = fld_w - 8 * 32'(byt_q);
        nbits  = (rem >= 8) ? 8 : rem;
        mask   = 8'((16'd1 << nbits) - 16'd1);
        placed = RecordWidth'(byte_i & mask) << (32'(base_q) + 8 * 32'(byt_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fld_q  <= '0;
            byt_q  <= '0;
            base_q <= '0;
            data_q <= '0;
        end else if (clr_i) begin
            fld_q  <= '0;
            byt_q  <= '0;
            base_q <= '0;
            data_q <= '0;
        end else if (valid_i) begin
            data_q <= data_q | placed;
            if (field_last) begin
                fld_q  <= fld_q + 3'd1;
                byt_q  <= '0;
                base_q <= base_q + OffW'(fld_w);
            end else begin
                byt_q <= byt_q + 3'd1;
            end
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/envm_pattern_loader.sv
// Frame parser that writes SA/TD/MBIST pattern records from a byte stream into
// the eNVM pattern store, with checksum and count validation.
module envm_pattern_loader
    import strait_pkg::*;
#(
    parameter int unsigned WEIGHT_WIDTH          = 8,
    parameter int unsigned ACTIVATION_WIDTH      = 8,
    parameter int unsigned PARTIAL_SUM_WIDTH     = 19,
    parameter int unsigned SA_TEST_PATTERN_DEPTH = 12,
    parameter int unsigned TD_TEST_PATTERN_DEPTH = 18,
    parameter int unsigned MBIST_PATTERN_DEPTH   = 8,
    parameter int unsigned NVM_ADDR_WIDTH        = 5,
    parameter int unsigned RECORD_WIDTH          =
        2 * WEIGHT_WIDTH + 2 * ACTIVATION_WIDTH + 4 * PARTIAL_SUM_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic                      nvm_wr_en,
    output logic [1:0]                nvm_sel,
    output logic [NVM_ADDR_WIDTH-1:0] nvm_wr_addr,
    output logic [RECORD_WIDTH-1:0]   nvm_wr_data,
    output logic                      busy,
    output logic                      load_done,
    output logic [1:0]                err_code
);

    typedef enum logic [2:0] {StIdle, StCount, StData, StWrite, StCsum, StDone} state_e;

    state_e                    state_q;
    nvm_sel_e                  sel_q;
    err_e                      err_q;
    logic [7:0]                cnt_q;
    logic [7:0]                csum_q;
    logic [NVM_ADDR_WIDTH-1:0] idx_q;
    logic                      ready_q;
    logic                      wr_en_q;
    logic                      busy_q;
    logic                      done_q;

    logic                      accept;
    logic                      asm_valid;
    logic                      asm_clr;
    logic                      asm_last;
    logic [RECORD_WIDTH-1:0]   asm_data;
    nvm_sel_e                  hdr_sel;
    int unsigned               depth;

    assign accept    = in_valid && ready_q;
    assign asm_valid = accept && (state_q == StData);
    // Keeping the assembler cleared outside records holds wr_data at zero.
    assign asm_clr   = (state_q == StIdle) || (state_q == StWrite);

    always_comb begin
        case (in_data)
            HdrSa:    hdr_sel = SelSa;
            HdrTd:    hdr_sel = SelTd;
            HdrMbist: hdr_sel = SelMbist;
            default:  hdr_sel = SelNone;
        endcase
        case (sel_q)
            SelSa:    depth = SA_TEST_PATTERN_DEPTH;
            SelTd:    depth = TD_TEST_PATTERN_DEPTH;
            SelMbist: depth = MBIST_PATTERN_DEPTH;
            default:  depth = 0;
        endcase
    end

    envm_pattern_loader_field_assembler #(
        .WeightWidth (WEIGHT_WIDTH),
        .ActWidth    (ACTIVATION_WIDTH),
        .PsumWidth   (PARTIAL_SUM_WIDTH),
        .RecordWidth (RECORD_WIDTH)
    ) u_field_assembler (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (asm_clr),
        .valid_i (asm_valid),
        .sel_i   (sel_q),
        .byte_i  (in_data),
        .data_o  (asm_data),
        .last_o  (asm_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= SelNone;
            err_q   <= ErrOk;
            cnt_q   <= '0;
            csum_q  <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (hdr_sel != SelNone) begin
                            sel_q   <= hdr_sel;
                            err_q   <= ErrOk;
                            csum_q  <= '0;
                            idx_q   <= '0;
                            state_q <= StCount;
                        end else begin
                            err_q   <= ErrHeader;
                            done_q  <= 1'b1;
                            ready_q <= 1'b0;
                            state_q <= StDone;
                        end
                    end
                end
                StCount: begin
                    if (accept) begin
                        csum_q <= csum_q ^ in_data;
                        cnt_q  <= in_data;
                        if (in_data == 8'd0 || 32'(in_data) > depth) begin
                            err_q   <= ErrCount;
                            done_q  <= 1'b1;
                            ready_q <= 1'b0;
                            state_q <= StDone;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        csum_q <= csum_q ^ in_data;
                        if (asm_last) begin
                            wr_en_q <= 1'b1;
                            ready_q <= 1'b0;
                            state_q <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    idx_q   <= idx_q + NVM_ADDR_WIDTH'(1);
                    ready_q <= 1'b1;
                    state_q <= (32'(idx_q) + 1 == 32'(cnt_q)) ? StCsum : StData;
                end
                StCsum: begin
                    if (accept) begin
                        if (in_data != csum_q) begin
                            err_q <= ErrCsum;
                        end
                        done_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready    = ready_q;
    assign nvm_wr_en   = wr_en_q;
    assign nvm_sel     = sel_q;
    assign nvm_wr_addr = idx_q;
    assign nvm_wr_data = asm_data;
    assign busy        = busy_q;
    assign load_done   = done_q;
    assign err_code    = err_q;

endmodule

// File: doc/envm_pattern_loader.md
# envm_pattern_loader

Byte-stream loader that writes LBIST stuck-at (SA), LBIST transition-delay (TD) and MBIST test patterns into the eNVM pattern store and the MBIST data generator. It replaces simulation-only preloading with a hardware write path, so the hybrid BIST controller reads silicon-loaded patterns. It sits between the external test/config port and the eNVM/MBIST write ports, and runs only while no BIST session is active.

## Interface
- WEIGHT_WIDTH, 8, weight field width
- ACTIVATION_WIDTH, 8, activation field width
- PARTIAL_SUM_WIDTH, 19, psum/answer field width
- SA_TEST_PATTERN_DEPTH, 12, max SA records
- TD_TEST_PATTERN_DEPTH, 18, max TD records
- MBIST_PATTERN_DEPTH, 8, max MBIST words
- NVM_ADDR_WIDTH, 5, clog2 of largest depth
- RECORD_WIDTH, 2*WEIGHT_WIDTH+2*ACTIVATION_WIDTH+4*PARTIAL_SUM_WIDTH (108), write data width

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  byte present
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte
- nvm_wr_en  out  1  one-cycle record write strobe
- nvm_sel  out  2  target: 1=SA, 2=TD, 3=MBIST
- nvm_wr_addr  out  NVM_ADDR_WIDTH  record index
- nvm_wr_data  out  RECORD_WIDTH  packed record
- busy  out  1  frame in progress
- load_done  out  1  one-cycle end-of-frame pulse
- err_code  out  2  0 ok, 1 bad header, 2 bad count, 3 checksum

## Operation
- Byte accepted on a rising clk edge with in_valid && in_ready.
- Frame: header, count N, N records, checksum. Header 0xA5=SA, 0x5A=TD, 0x3C=MBIST.
- Field bytes per field = ceil(width/8), little-endian; bits above the field width are discarded. SA record: W,A,P,Ans = 8 bytes. TD: W1,W2,A1,A2,P1,P2,Launch,Capture = 16 bytes. MBIST: one psum word = 3 bytes.
- nvm_wr_data packing from LSB: SA {Ans,P,A,W}; TD {C,L,P2,P1,A2,A1,W2,W1}; MBIST {word}. Unused upper bits are 0.
- Checksum = XOR of every byte from count through the last record byte. The checksum byte must equal it.
- FSM states: IDLE, COUNT, DATA, WRITE, CSUM, DONE.
  - IDLE: a valid header goes to COUNT and clears err_code. An invalid header sets err=1 and goes to DONE.
  - COUNT: N=0 or N>depth(section) sets err=2 and goes to DONE. Otherwise go to DATA.
  - DATA: assemble bytes. The last byte of a record goes to WRITE.
  - WRITE: nvm_wr_en=1 for one cycle, addr = record index, then increment. Go to DATA if records remain, else CSUM.
  - CSUM: compare the checksum byte. A mismatch sets err=3. Go to DONE.
  - DONE: load_done=1 for one cycle, then IDLE.
- Records already written stay written when the checksum fails. Software must not START BIST when err_code is non-zero.
- in_valid gaps are allowed anywhere in the frame. State and counters hold during a gap.

## Timing
- Reset values: in_ready=0 while rst_n is low and 1 in IDLE after reset; nvm_wr_en=0, nvm_sel=0, nvm_wr_addr=0, nvm_wr_data=0, busy=0, load_done=0, err_code=0.
- in_ready=1 in IDLE, COUNT, DATA and CSUM; 0 in WRITE and DONE.
- nvm_wr_en asserts the cycle after the record's last byte is accepted. Data, addr and sel are stable in that cycle.
- load_done asserts the cycle after the checksum byte (or the erroring header/count byte) is accepted.
- busy=1 from the cycle after header acceptance until load_done, inclusive.
- err_code holds until the next valid header is accepted.
- A back-to-back frame needs 1 gap cycle per record and 1 after DONE. Minimum SA frame length = 3 + 9N cycles.
- Reset mid-frame aborts immediately with no further writes. Partially written eNVM content is undefined until reloaded.

## Structure
- The shared package strait_pkg holds the header codes, the nvm_sel encodings, the err_code values, a bytes-per-field function, and the SA/TD/MBIST record byte counts.
- One sub-module, field_assembler: a byte counter and shift register that places each byte at its packed bit offset, with clear on record start. The FSM and checksum stay in the parent.

## Test plan
- SA, N=1: A5 01 12 34 05 00 00 AD 03 00 8C -> one write, sel=1, addr=0, W=0x12, A=0x34, P=5, Ans=0x3AD; load_done with err=0.
- TD, N=18, random fields and correct checksum -> 18 writes, addr 0..17, packed fields match the model, err=0.
- Header 0xFF -> no writes, load_done the next cycle, err=1; the next valid frame clears err.
- SA count 13 (0x0D) -> err=2, no writes; MBIST count 8 is accepted.
- SA N=1 with checksum 0x8D -> write still occurs, err=3.
- Random in_valid gaps plus rst_n low mid-record -> all outputs return to reset values, no wr_en pulse; a following clean frame loads correctly.
